npu_seq_ctrl: RTL and testbench
===============================

Name: npu_seq_ctrl

Overview:
Parametrised host-mapped sequencer for the NPU datapath. It replaces the fixed two-pass conv1/conv2 flow with a configurable loop of NUM_LAYERS × channel passes, followed by the FC stage. It drives the conv engine, the partial-sum buffer and the FCN engine with single-cycle pulses. Handshakes: conv_done back from the conv engine, fcn_done back from the FCN engine. Two run modes: auto (free-running) and step (host-acknowledged per pass).

Parameters:
ADDR_W, 16, host address width
DATA_W, 32, host data width
MAX_LAYERS, 4, maximum conv layers per run (≥1)
MAX_CHAN, 16, maximum channel passes per layer (≥1)
LOGIT_W, 24, signed FCN result width (≤DATA_W)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ena  in  1  host access enable
wea  in  1  host write (1) / read (0)
addra  in  ADDR_W  host address; register index = addra[3:0]
dina  in  DATA_W  host write data
douta  out  DATA_W  host read data, registered
conv_trigger  out  1  pulse: start one conv pass
conv_layer  out  $clog2(MAX_LAYERS)  current layer index
conv_chan  out  $clog2(MAX_CHAN)  current channel index
conv_clear_addr  out  1  pulse: reset conv pixel address
conv_done  in  1  pulse: conv pass finished
psum_clear  out  1  pulse: clear partial-sum buffer
psum_ce  out  1  high while layer index ≥1 (accumulate enable)
fcn_start  out  1  pulse: start FC stage
fcn_done  in  1  pulse: FC finished
fcn_logit  in  LOGIT_W  signed FC result, valid with fcn_done
busy  out  1  sequencer not idle
irq  out  1  one-cycle pulse on run completion

Behaviour:
Reset values:
- All outputs 0; douta 0.
- cfg_chan = 1, cfg_layers = 1, auto = 0.
- done, err and result cleared.

Register map (index addra[3:0]):
- 0 CTRL, write: bit0 start, bit1 auto, bit2 abort, bit3 clr_done.
- 1 CFG, read/write: [7:0] chans per layer, [11:8] layers.
- 2 STATUS, read: bit0 done (sticky), bit1 busy, bit2 err (sticky), [7:4] state code, [15:8] conv_chan, [19:16] conv_layer.
- 3 RESULT, read: fcn_logit sign-extended to DATA_W.
- 4 ACK, write: continue in step mode.

Host bus:
- Read: douta updates on the cycle after ena & ~wea; unmapped index returns 0; douta holds when not reading.
- Write: takes effect on the clock edge where ena & wea.

State machine (state codes in order):
- IDLE(0): on start, clear layer/chan, latch auto → TRIG. Start while busy → err set, request ignored.
- TRIG(1): assert conv_trigger for 1 cycle. Assert psum_clear in the same cycle when chan==0 and layer≥1 → RUN.
- RUN(2): wait for conv_done, then pulse conv_clear_addr → NEXT. conv_done in any other state is ignored.
- NEXT(3): advance the channel/layer counters:
  - chan<cfg_chan-1: chan++.
  - chan = last, layer<cfg_layers-1: chan=0, layer++.
  - Both last: → FCN.
  - Otherwise: auto → TRIG, step → HOLD.
- HOLD(4): wait for an ACK write → TRIG.
- FCN(5): pulse fcn_start → FWAIT.
- FWAIT(6): on fcn_done, capture fcn_logit into RESULT → DONE.
- DONE(7): set done, pulse irq → IDLE.

Status and counter rules:
- busy = (state != IDLE).
- psum_ce = (layer ≥ 1).
- Worst-case latency per pass = conv engine time + 3 cycles.

Configuration and control:
- CFG write while busy → rejected, err set, old value kept.
- CFG write with chans = 0 or > MAX_CHAN, or layers = 0 or > MAX_LAYERS → rejected, err set.
- clr_done clears both done and err.
- Abort in any state: → IDLE next cycle, conv_clear_addr pulsed, done not set, RESULT unchanged.

Simultaneous events:
- abort beats start, ack and conv_done.
- start together with clr_done: done/err clear first, then the run starts.
- Read of STATUS in the same cycle as a state change returns the pre-edge value.

Reset mid-operation: everything returns to reset values immediately; no pulses are emitted.

Decomposition:
- Package npu_pkg holds:
  - the seq_state_e enum (3-bit, the codes above);
  - register index localparams (REG_CTRL=0 … REG_ACK=4);
  - CTRL bit-position constants.
- One sub-module, npu_host_regs: register decode, CFG validation, sticky done/err, and the registered read mux. The FSM and counters stay in npu_seq_ctrl.

Test Plan:
- CFG = 3 chans / 2 layers, auto, start; conv_done 20 cycles after each trigger; fcn_done with logit = -5. Required: 6 conv_trigger pulses; psum_clear only on pass 4; RESULT = 0xFFFFFFFB; done = 1; irq pulsed once.
- Step mode with 2×1 configuration. Required: parks in HOLD (STATUS[7:4] = 4) after pass 1; no second trigger until the ACK write; trigger issued on the cycle after ACK.
- CFG write chans = 0, then chans = 17. Required: err = 1 both times; CFG readback unchanged at the previous valid value.
- Abort asserted in RUN. Required: state IDLE next cycle; conv_clear_addr pulsed; busy = 0; done = 0; a later conv_done is ignored.
- Start while busy. Required: err = 1; sequence continues unaffected. A following clr_done clears err and done.
- Assert rst in FWAIT. Required: all outputs 0 asynchronously; CFG reads back 0x101 after reset release.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared definitions for the NPU sequencer: state encoding, host register
// indices, CTRL bit positions and a small width helper.
package npu_pkg;

    // Sequencer states; the numeric codes are visible to the host in STATUS[7:4]
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRIG  = 3'd1,
        S_RUN   = 3'd2,
        S_NEXT  = 3'd3,
        S_HOLD  = 3'd4,
        S_FCN   = 3'd5,
        S_FWAIT = 3'd6,
        S_DONE  = 3'd7
    } seq_state_e;

    // Host register indices (taken from addra[3:0])
    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_CFG    = 4'd1;
    localparam logic [3:0] REG_STATUS = 4'd2;
    localparam logic [3:0] REG_RESULT = 4'd3;
    localparam logic [3:0] REG_ACK    = 4'd4;

    // Bit positions inside a CTRL write
    localparam int CTRL_START    = 0;
    localparam int CTRL_AUTO     = 1;
    localparam int CTRL_ABORT    = 2;
    localparam int CTRL_CLR_DONE = 3;

    // Index width for a counter that must reach n-1; never narrower than one bit
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/npu_host_regs.sv
// Host-facing register block of the NPU sequencer. Decodes host writes into
// control strobes, validates and holds the CFG register, keeps the sticky
// done/err flags and the FC result, and drives the registered read port.
// Strobes are combinational so the sequencer reacts on the same clock edge
// that performs the write.
module npu_host_regs
    import npu_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MAX_LAYERS = 4,
    parameter int MAX_CHAN   = 16,
    parameter int LOGIT_W    = 24,
    parameter int CHAN_W     = 4,
    parameter int LAYER_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               wea,
    input  logic [ADDR_W-1:0]  addra,
    input  logic [DATA_W-1:0]  dina,
    output logic [DATA_W-1:0]  douta,
    input  seq_state_e         state,
    input  logic               busy,
    input  logic [CHAN_W-1:0]  cur_chan,
    input  logic [LAYER_W-1:0] cur_layer,
    input  logic               set_done,
    input  logic               capture,
    input  logic [LOGIT_W-1:0] fcn_logit,
    output logic               start_req,
    output logic               abort_req,
    output logic               ack_req,
    output logic               auto_req,
    output logic [7:0]         cfg_chan,
    output logic [3:0]         cfg_layers
);

    localparam logic [7:0] CHAN_LIMIT  = 8'(MAX_CHAN);
    localparam logic [3:0] LAYER_LIMIT = 4'(MAX_LAYERS);

    logic [3:0]        reg_idx;
    logic              wr_en;
    logic              rd_en;
    logic              ctrl_wr;
    logic              cfg_wr;
    logic              clr_req;
    logic              cfg_ok;
    logic [7:0]        new_chan;
    logic [3:0]        new_layers;
    logic              done;
    logic              err;
    logic              done_n;
    logic              err_n;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] cfg_word;
    logic [DATA_W-1:0] status_word;
    logic              unused_bits;

    assign reg_idx    = addra[3:0];
    assign wr_en      = ena & wea;
    assign rd_en      = ena & ~wea;
    assign ctrl_wr    = wr_en && (reg_idx == REG_CTRL);
    assign cfg_wr     = wr_en && (reg_idx == REG_CFG);
    assign ack_req    = wr_en && (reg_idx == REG_ACK);

    assign start_req  = ctrl_wr & dina[CTRL_START];
    assign auto_req   = ctrl_wr & dina[CTRL_AUTO];
    assign abort_req  = ctrl_wr & dina[CTRL_ABORT];
    assign clr_req    = ctrl_wr & dina[CTRL_CLR_DONE];

    assign new_chan   = dina[7:0];
    assign new_layers = dina[11:8];
    assign cfg_ok     = (new_chan != 8'd0) && (new_chan <= CHAN_LIMIT) &&
                        (new_layers != 4'd0) && (new_layers <= LAYER_LIMIT);

    // Address bits above the index and data bits above CFG are don't-care
    assign unused_bits = ^{addra[ADDR_W-1:4], dina[DATA_W-1:12]};

    // Sticky flags: clr_done acts first, then any new set condition of this cycle
    always_comb begin
        done_n = done;
        err_n  = err;
        if (clr_req) begin
            done_n = 1'b0;
            err_n  = 1'b0;
        end
        if (set_done) begin
            done_n = 1'b1;
        end
        if ((start_req && busy && !abort_req) || (cfg_wr && (busy || !cfg_ok))) begin
            err_n = 1'b1;
        end
    end

    // Sticky flag storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= done_n;
            err  <= err_n;
        end
    end

    // CFG only changes on a valid write while the sequencer is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_chan   <= 8'd1;
            cfg_layers <= 4'd1;
        end else if (cfg_wr && !busy && cfg_ok) begin
            cfg_chan   <= new_chan;
            cfg_layers <= new_layers;
        end
    end

    // FC result is captured sign-extended so the host reads a full-width integer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (capture) begin
            result <= DATA_W'($signed(fcn_logit));
        end
    end

    // Assemble the readable words from the live (pre-edge) values
    always_comb begin
        cfg_word           = '0;
        cfg_word[11:0]     = {cfg_layers, cfg_chan};
        status_word        = '0;
        status_word[0]     = done;
        status_word[1]     = busy;
        status_word[2]     = err;
        status_word[7:4]   = {1'b0, state};
        status_word[15:8]  = 8'(cur_chan);
        status_word[19:16] = 4'(cur_layer);
    end

    // Registered read port; holds its value between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            douta <= '0;
        end else if (rd_en) begin
            case (reg_idx)
                REG_CFG:    douta <= cfg_word;
                REG_STATUS: douta <= status_word;
                REG_RESULT: douta <= result;
                default:    douta <= '0;
            endcase
        end
    end

endmodule

// File: rtl/npu_seq_ctrl.sv
// NPU sequencer top. Walks layers x channels of conv passes, then runs the
// FC stage, issuing single-cycle pulses to the conv engine, partial-sum
// buffer and FCN engine. Auto mode free-runs between passes; step mode parks
// after each pass until the host writes ACK. Abort returns to idle at once.
module npu_seq_ctrl
    import npu_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MAX_LAYERS = 4,
    parameter int MAX_CHAN   = 16,
    parameter int LOGIT_W    = 24
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ena,
    input  logic                              wea,
    input  logic [ADDR_W-1:0]                 addra,
    input  logic [DATA_W-1:0]                 dina,
    output logic [DATA_W-1:0]                 douta,
    output logic                              conv_trigger,
    output logic [width_of(MAX_LAYERS)-1:0]   conv_layer,
    output logic [width_of(MAX_CHAN)-1:0]     conv_chan,
    output logic                              conv_clear_addr,
    input  logic                              conv_done,
    output logic                              psum_clear,
    output logic                              psum_ce,
    output logic                              fcn_start,
    input  logic                              fcn_done,
    input  logic [LOGIT_W-1:0]                fcn_logit,
    output logic                              busy,
    output logic                              irq
);

    localparam int LAYER_W = width_of(MAX_LAYERS);
    localparam int CHAN_W  = width_of(MAX_CHAN);

    seq_state_e         state;
    seq_state_e         state_n;
    logic [CHAN_W-1:0]  chan;
    logic [CHAN_W-1:0]  chan_n;
    logic [LAYER_W-1:0] layer;
    logic [LAYER_W-1:0] layer_n;
    logic               auto_q;
    logic               auto_n;
    logic               clr_addr_q;
    logic               start_req;
    logic               abort_req;
    logic               ack_req;
    logic               auto_req;
    logic [7:0]         cfg_chan;
    logic [3:0]         cfg_layers;
    logic               chan_last;
    logic               layer_last;
    logic               set_done;
    logic               capture;

    npu_host_regs #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_LAYERS (MAX_LAYERS),
        .MAX_CHAN   (MAX_CHAN),
        .LOGIT_W    (LOGIT_W),
        .CHAN_W     (CHAN_W),
        .LAYER_W    (LAYER_W)
    ) u_regs (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .douta      (douta),
        .state      (state),
        .busy       (busy),
        .cur_chan   (chan),
        .cur_layer  (layer),
        .set_done   (set_done),
        .capture    (capture),
        .fcn_logit  (fcn_logit),
        .start_req  (start_req),
        .abort_req  (abort_req),
        .ack_req    (ack_req),
        .auto_req   (auto_req),
        .cfg_chan   (cfg_chan),
        .cfg_layers (cfg_layers)
    );

    assign chan_last  = (8'(chan) == (cfg_chan - 8'd1));
    assign layer_last = (4'(layer) == (cfg_layers - 4'd1));

    // Completion and capture are suppressed when an abort lands in the same cycle
    assign set_done = (state == S_DONE) && !abort_req;
    assign capture  = (state == S_FWAIT) && fcn_done && !abort_req;

    // State, pass counters and latched run mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            chan   <= '0;
            layer  <= '0;
            auto_q <= 1'b0;
        end else begin
            state  <= state_n;
            chan   <= chan_n;
            layer  <= layer_n;
            auto_q <= auto_n;
        end
    end

    // Next-state and counter update; abort overrides every other event
    always_comb begin
        state_n = state;
        chan_n  = chan;
        layer_n = layer;
        auto_n  = auto_q;
        if (abort_req) begin
            state_n = S_IDLE;
            chan_n  = '0;
            layer_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        chan_n  = '0;
                        layer_n = '0;
                        auto_n  = auto_req;
                        state_n = S_TRIG;
                    end
                end
                S_TRIG: begin
                    state_n = S_RUN;
                end
                S_RUN: begin
                    if (conv_done) begin
                        state_n = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (chan_last && layer_last) begin
                        state_n = S_FCN;
                    end else begin
                        if (!chan_last) begin
                            chan_n = chan + CHAN_W'(1);
                        end else begin
                            chan_n  = '0;
                            layer_n = layer + LAYER_W'(1);
                        end
                        state_n = auto_q ? S_TRIG : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ack_req) begin
                        state_n = S_TRIG;
                    end
                end
                S_FCN: begin
                    state_n = S_FWAIT;
                end
                S_FWAIT: begin
                    if (fcn_done) begin
                        state_n = S_DONE;
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // Address-clear pulse follows either a finished pass or an abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr_q <= 1'b0;
        end else begin
            clr_addr_q <= abort_req || ((state == S_RUN) && conv_done);
        end
    end

    assign conv_trigger    = (state == S_TRIG);
    assign psum_clear      = (state == S_TRIG) && (chan == '0) && (layer != '0);
    assign psum_ce         = (layer != '0);
    assign conv_clear_addr = clr_addr_q;
    assign fcn_start       = (state == S_FCN);
    assign irq             = (state == S_DONE);
    assign busy            = (state != S_IDLE);
    assign conv_layer      = layer;
    assign conv_chan       = chan;

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Self-checking bench for npu_seq_ctrl. Behavioural conv/FCN engine models
// answer the sequencer's pulses; a monitor logs every conv trigger. Expected
// pass order, psum behaviour and results come from plain arithmetic on the
// configured channel/layer counts.
module tb_npu_seq_ctrl;

    localparam logic [3:0] I_CTRL   = 4'd0;
    localparam logic [3:0] I_CFG    = 4'd1;
    localparam logic [3:0] I_STATUS = 4'd2;
    localparam logic [3:0] I_RESULT = 4'd3;
    localparam logic [3:0] I_ACK    = 4'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        wea = 1'b0;
    logic [15:0] addra = '0;
    logic [31:0] dina = '0;
    logic [31:0] douta;
    logic        conv_trigger;
    logic [1:0]  conv_layer;
    logic [3:0]  conv_chan;
    logic        conv_clear_addr;
    logic        conv_done;
    logic        psum_clear;
    logic        psum_ce;
    logic        fcn_start;
    logic        fcn_done;
    logic [23:0] fcn_logit;
    logic        busy;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic clr;
        logic ce;
        int   layer;
        int   chan;
    } trig_rec_t;

    typedef struct {
        int          chans;
        int          layers;
        logic [31:0] exp_cfg;
        logic        exp_err;
    } cfg_vec_t;

    trig_rec_t   trig_log[$];
    cfg_vec_t    cfg_tab[8];
    int          irq_cnt = 0;
    int          fcn_cnt = 0;
    int          clr_addr_cnt = 0;
    int          psum_clr_cnt = 0;
    int          conv_lat = 4;
    int          fcn_lat = 3;
    logic        fcn_resp = 1'b1;
    logic [23:0] fcn_value = '0;
    int          conv_cd = 0;
    int          fcn_cd = 0;
    logic [31:0] rd;
    logic [31:0] model_cfg;

    npu_seq_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .ena             (ena),
        .wea             (wea),
        .addra           (addra),
        .dina            (dina),
        .douta           (douta),
        .conv_trigger    (conv_trigger),
        .conv_layer      (conv_layer),
        .conv_chan       (conv_chan),
        .conv_clear_addr (conv_clear_addr),
        .conv_done       (conv_done),
        .psum_clear      (psum_clear),
        .psum_ce         (psum_ce),
        .fcn_start       (fcn_start),
        .fcn_done        (fcn_done),
        .fcn_logit       (fcn_logit),
        .busy            (busy),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    // Conv engine: conv_done conv_lat cycles after each trigger
    initial begin
        conv_done = 1'b0;
        forever begin
            @(negedge clk);
            conv_done = 1'b0;
            if (rst) begin
                conv_cd = 0;
            end else begin
                if (conv_cd > 0) begin
                    conv_cd--;
                    if (conv_cd == 0) conv_done = 1'b1;
                end
                if (conv_trigger) conv_cd = conv_lat;
            end
        end
    end

    // FCN engine: fcn_done plus logit fcn_lat cycles after fcn_start
    initial begin
        fcn_done  = 1'b0;
        fcn_logit = '0;
        forever begin
            @(negedge clk);
            fcn_done = 1'b0;
            if (rst) begin
                fcn_cd = 0;
            end else begin
                if (fcn_cd > 0) begin
                    fcn_cd--;
                    if (fcn_cd == 0) begin
                        fcn_done  = 1'b1;
                        fcn_logit = fcn_value;
                    end
                end
                if (fcn_start && fcn_resp) fcn_cd = fcn_lat;
            end
        end
    end

    // Monitor of sequencer pulses
    always @(negedge clk) begin
        if (conv_trigger) trig_log.push_back('{psum_clear, psum_ce, int'(conv_layer), int'(conv_chan)});
        if (irq) irq_cnt++;
        if (fcn_start) fcn_cnt++;
        if (conv_clear_addr) clr_addr_cnt++;
        if (psum_clear) psum_clr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic host_write(input logic [3:0] idx, input logic [31:0] data);
        @(negedge clk);
        ena = 1'b1; wea = 1'b1; addra = {12'h0, idx}; dina = data;
        @(negedge clk);
        ena = 1'b0; wea = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] idx, output logic [31:0] data);
        @(negedge clk);
        ena = 1'b1; wea = 1'b0; addra = {12'h0, idx};
        @(negedge clk);
        ena = 1'b0;
        data = douta;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput({name, "_finish"}, 32'(busy), 32'd0);
    endtask

    task automatic poll_state(input logic [3:0] code, input string name);
        logic [31:0] d = '0;
        int k = 0;
        do begin
            host_read(I_STATUS, d);
            k++;
        end while (d[7:4] != code && k < 60);
        checkOutput(name, 32'(d[7:4]), 32'(code));
    endtask

    // Table vector: clear err, write CFG, then check readback and err flag
    task automatic applyStimulus(input cfg_vec_t v, input int n);
        logic [31:0] d;
        host_write(I_CTRL, 32'h8);
        host_write(I_CFG, 32'({4'(v.layers), 8'(v.chans)}));
        host_read(I_CFG, d);
        checkOutput($sformatf("cfg_tab%0d_readback", n), d, v.exp_cfg);
        host_read(I_STATUS, d);
        checkOutput($sformatf("cfg_tab%0d_err", n), 32'(d[2]), 32'(v.exp_err));
    endtask

    // Full auto run checked against the pass-order model
    task automatic run_and_check(input int c, input int l, input int lat, input logic [23:0] logit, input string name);
        int base_t, base_irq, base_fcn, base_pclr, n, lim;
        logic [31:0] d, exp_res;
        trig_rec_t rec;
        conv_lat = lat;
        fcn_value = logit;
        host_write(I_CTRL, 32'h8);
        host_write(I_CFG, 32'({4'(l), 8'(c)}));
        base_t = trig_log.size();
        base_irq = irq_cnt;
        base_fcn = fcn_cnt;
        base_pclr = psum_clr_cnt;
        host_write(I_CTRL, 32'h3);
        wait_idle(c * l * (lat + 6) + 80, name);
        @(negedge clk);
        n = trig_log.size() - base_t;
        checkOutput({name, "_passes"}, 32'(n), 32'(c * l));
        lim = (n < c * l) ? n : c * l;
        for (int p = 0; p < lim; p++) begin
            rec = trig_log[base_t + p];
            checkOutput($sformatf("%s_pass%0d", name, p),
                        32'({rec.clr, rec.ce, 8'(rec.layer), 8'(rec.chan)}),
                        32'({(p >= c) && (p % c == 0), p >= c, 8'(p / c), 8'(p % c)}));
        end
        checkOutput({name, "_irq"}, 32'(irq_cnt - base_irq), 32'd1);
        checkOutput({name, "_fcn_start"}, 32'(fcn_cnt - base_fcn), 32'd1);
        checkOutput({name, "_psum_clears"}, 32'(psum_clr_cnt - base_pclr), 32'(l - 1));
        exp_res = logit[23] ? {8'hFF, logit} : {8'h00, logit};
        host_read(I_RESULT, d);
        checkOutput({name, "_result"}, d, exp_res);
        host_read(I_STATUS, d);
        checkOutput({name, "_status"}, 32'(d[7:0]), 32'h01);
    endtask

    initial begin
        int base_t, base_irq, base_clr;
        $display("[TB] start");

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    32'({busy, irq, conv_trigger, conv_clear_addr, psum_clear, psum_ce, fcn_start, conv_layer, conv_chan}),
                    32'd0);
        rst = 1'b0;
        host_read(I_CFG, rd);
        checkOutput("reset_cfg", rd, 32'h101);
        host_read(I_STATUS, rd);
        checkOutput("reset_status", rd, 32'h0);
        host_read(I_RESULT, rd);
        checkOutput("reset_result", rd, 32'h0);

        // CFG validation table
        cfg_tab[0] = '{3, 2, 32'h203, 1'b0};
        cfg_tab[1] = '{0, 2, 32'h203, 1'b1};
        cfg_tab[2] = '{17, 2, 32'h203, 1'b1};
        cfg_tab[3] = '{16, 4, 32'h410, 1'b0};
        cfg_tab[4] = '{1, 5, 32'h410, 1'b1};
        cfg_tab[5] = '{1, 0, 32'h410, 1'b1};
        cfg_tab[6] = '{1, 1, 32'h101, 1'b0};
        cfg_tab[7] = '{3, 2, 32'h203, 1'b0};
        for (int i = 0; i < 8; i++) applyStimulus(cfg_tab[i], i);

        // Randomized CFG writes against a validity model
        model_cfg = 32'h203;
        for (int i = 0; i < 12; i++) begin
            int c, l;
            logic ok;
            c = $urandom_range(0, 20);
            l = $urandom_range(0, 6);
            ok = (c >= 1) && (c <= 16) && (l >= 1) && (l <= 4);
            if (ok) model_cfg = 32'(l * 256 + c);
            host_write(I_CTRL, 32'h8);
            host_write(I_CFG, 32'(l * 256 + c));
            host_read(I_CFG, rd);
            checkOutput($sformatf("rand_cfg%0d_readback", i), rd, model_cfg);
            host_read(I_STATUS, rd);
            checkOutput($sformatf("rand_cfg%0d_err", i), 32'(rd[2]), 32'(!ok));
        end

        // Reference run: 3 chans x 2 layers, 20-cycle conv, logit -5
        run_and_check(3, 2, 20, 24'hFFFFFB, "run3x2");
        host_read(I_RESULT, rd);
        checkOutput("run3x2_result_const", rd, 32'hFFFF_FFFB);

        // Step mode 2 chans x 1 layer
        host_write(I_CTRL, 32'h8);
        conv_lat = 5;
        host_write(I_CFG, 32'h102);
        base_t = trig_log.size();
        base_irq = irq_cnt;
        host_write(I_CTRL, 32'h1);
        poll_state(4'd4, "step_hold_state");
        checkOutput("step_one_trigger", 32'(trig_log.size() - base_t), 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("step_no_trigger_before_ack", 32'(trig_log.size() - base_t), 32'd1);
        checkOutput("step_trigger_low", 32'(conv_trigger), 32'd0);
        host_write(I_ACK, 32'h0);
        checkOutput("step_trigger_after_ack", 32'(conv_trigger), 32'd1);
        wait_idle(100, "step");
        @(negedge clk);
        checkOutput("step_passes", 32'(trig_log.size() - base_t), 32'd2);
        checkOutput("step_irq", 32'(irq_cnt - base_irq), 32'd1);

        // Abort while in RUN
        host_write(I_CTRL, 32'h8);
        conv_lat = 10;
        host_write(I_CFG, 32'h202);
        base_t = trig_log.size();
        host_write(I_CTRL, 32'h3);
        @(negedge clk);
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        base_clr = clr_addr_cnt;
        host_write(I_CTRL, 32'h4);
        checkOutput("abort_clear_addr", 32'(conv_clear_addr), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        host_read(I_STATUS, rd);
        checkOutput("abort_status", 32'({rd[7:4], rd[0]}), 32'd0);
        repeat (15) @(negedge clk);
        checkOutput("abort_late_done_ignored", 32'(trig_log.size() - base_t), 32'd1);
        checkOutput("abort_still_idle", 32'(busy), 32'd0);
        checkOutput("abort_single_clear", 32'(clr_addr_cnt - base_clr), 32'd1);

        // Start while busy
        host_write(I_CTRL, 32'h8);
        conv_lat = 8;
        host_write(I_CFG, 32'h102);
        base_t = trig_log.size();
        base_irq = irq_cnt;
        host_write(I_CTRL, 32'h3);
        repeat (3) @(negedge clk);
        host_write(I_CTRL, 32'h3);
        host_read(I_STATUS, rd);
        checkOutput("busy_start_err", 32'(rd[2:1]), 32'b11);
        wait_idle(100, "busy_start");
        @(negedge clk);
        checkOutput("busy_start_passes", 32'(trig_log.size() - base_t), 32'd2);
        checkOutput("busy_start_irq", 32'(irq_cnt - base_irq), 32'd1);
        host_read(I_STATUS, rd);
        checkOutput("busy_start_flags", 32'(rd[2:0]), 32'b101);
        host_write(I_CTRL, 32'h8);
        host_read(I_STATUS, rd);
        checkOutput("clr_done_flags", 32'(rd[2:0]), 32'b000);

        // Randomized auto runs
        for (int i = 0; i < 8; i++) begin
            int c, l, lat;
            c = $urandom_range(1, 5);
            l = $urandom_range(1, 4);
            lat = $urandom_range(1, 6);
            fcn_lat = $urandom_range(1, 4);
            run_and_check(c, l, lat, 24'($urandom), $sformatf("rand_run%0d", i));
        end

        // Reset while waiting for the FC stage
        fcn_resp = 1'b0;
        conv_lat = 4;
        host_write(I_CFG, 32'h101);
        host_write(I_CTRL, 32'h3);
        poll_state(4'd6, "fwait_state");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_outputs",
                    32'({busy, irq, conv_trigger, conv_clear_addr, psum_clear, psum_ce, fcn_start, conv_layer, conv_chan}),
                    32'd0);
        checkOutput("rst_async_douta", douta, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fcn_resp = 1'b1;
        host_read(I_CFG, rd);
        checkOutput("rst_cfg_readback", rd, 32'h101);
        host_read(I_STATUS, rd);
        checkOutput("rst_status", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
